imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe.sv | 133 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: combinational decode of the I/S/B/U/J formats
// feeding a main register plus a one-deep skid register behind a valid/ready handshake.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [ILEN-1:0] i_Instruction,
    input  logic            i_Valid,
    output logic            o_Ready,
    output logic [XLEN-1:0] o_ExtendedImmediate,
    output logic [2:0]      o_ImmType,
    output logic            o_Illegal,
    output logic [ILEN-1:0] o_Instruction,
    output logic            o_Valid,
    input  logic            i_Ready,
    input  logic            i_Flush
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       typ;
        logic            illegal;
        logic [ILEN-1:0] instr;
        logic            valid;
    } beat_t;

    logic [ILEN-1:0] ins;
    logic [31:0]     imm32;
    beat_t           dec_beat;
    beat_t           m_q, m_d;
    beat_t           s_q, s_d;
    logic            accept;
    logic            m_fire;

    assign ins = i_Instruction;

    // Every format is first built as a 32-bit value whose bit 31 is ins[31]; the signed
    // size cast then replicates that bit up to XLEN, which covers RV64 U-type as well.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        dec_beat       = '0;
        imm32          = '0;
        dec_beat.instr = ins;
        dec_beat.valid = 1'b1;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_beat.typ = IMM_I;
                imm32        = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                dec_beat.typ = IMM_S;
                imm32        = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec_beat.typ = IMM_B;
                imm32        = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_beat.typ = IMM_U;
                imm32        = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_beat.typ = IMM_J;
                imm32        = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: begin
                dec_beat.typ     = IMM_NONE;
                dec_beat.illegal = 1'b1;
            end
        endcase
        dec_beat.imm = XLEN'($signed(imm32));
    end

    // o_Ready depends only on the skid register, never combinationally on i_Ready.
    assign o_Ready = ~s_q.valid;
    assign accept  = i_Valid & o_Ready;
    assign m_fire  = m_q.valid & i_Ready;

    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (i_Flush) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (!m_q.valid || m_fire) begin
            if (s_q.valid) begin
                m_d = s_q;
                if (accept) begin
                    s_d = dec_beat;
                end else begin
                    s_d.valid = 1'b0;
                end
            end else if (accept) begin
                m_d = dec_beat;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (accept) begin
            s_d = dec_beat;
        end
    end

    // NOTE: both registers are small flop banks, so resetting their data fields is cheap and
    // guarantees all-zero outputs straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            // NOTE: non-blocking updates so both registers sample the same pre-edge state.
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign o_ExtendedImmediate = m_q.imm;
    assign o_ImmType           = m_q.typ;
    assign o_Illegal           = m_q.illegal;
    assign o_Instruction       = m_q.instr;
    assign o_Valid             = m_q.valid;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table through XLEN=32 and XLEN=64 instances,
// then stall/skid ordering, flush and asynchronous reset sequences.
module tb_imm_gen_pipe;

    logic        clk;
    logic        i_rst;
    logic [31:0] i_Instruction;
    logic        i_Valid;
    logic        i_Ready;
    logic        i_Flush;

    logic        o32_Ready, o32_Illegal, o32_Valid;
    logic [31:0] o32_Imm, o32_Instruction;
    logic [2:0]  o32_ImmType;

    logic        o64_Ready, o64_Illegal, o64_Valid;
    logic [63:0] o64_Imm;
    logic [31:0] o64_Instruction;
    logic [2:0]  o64_ImmType;

    int n_checks = 0;
    int n_errors = 0;

    imm_gen_pipe #(.XLEN(32), .ILEN(32)) dut32 (
        .i_clk               (clk),
        .i_rst               (i_rst),
        .i_Instruction       (i_Instruction),
        .i_Valid             (i_Valid),
        .o_Ready             (o32_Ready),
        .o_ExtendedImmediate (o32_Imm),
        .o_ImmType           (o32_ImmType),
        .o_Illegal           (o32_Illegal),
        .o_Instruction       (o32_Instruction),
        .o_Valid             (o32_Valid),
        .i_Ready             (i_Ready),
        .i_Flush             (i_Flush)
    );

    imm_gen_pipe #(.XLEN(64), .ILEN(32)) dut64 (
        .i_clk               (clk),
        .i_rst               (i_rst),
        .i_Instruction       (i_Instruction),
        .i_Valid             (i_Valid),
        .o_Ready             (o64_Ready),
        .o_ExtendedImmediate (o64_Imm),
        .o_ImmType           (o64_ImmType),
        .o_Illegal           (o64_Illegal),
        .o_Instruction       (o64_Instruction),
        .o_Valid             (o64_Valid),
        .i_Ready             (i_Ready),
        .i_Flush             (i_Flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0}; // addi x1,x0,-1
        vecs[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0}; // beq -4
        vecs[2]  = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0}; // jal +2048
        vecs[3]  = '{32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0}; // lui
        vecs[4]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // lui, sign bit set
        vecs[5]  = '{32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0}; // sw x2,-8(x1)
        vecs[6]  = '{32'h7FF02283, 64'h0000_0000_0000_07FF, 3'd1, 1'b0}; // lw x5,2047(x0)
        vecs[7]  = '{32'h000080E7, 64'h0000_0000_0000_0000, 3'd1, 1'b0}; // jalr x1,0(x1)
        vecs[8]  = '{32'h00001017, 64'h0000_0000_0000_1000, 3'd4, 1'b0}; // auipc
        vecs[9]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0}; // jal -4
        vecs[10] = '{32'h002081B3, 64'h0000_0000_0000_0000, 3'd0, 1'b1}; // add (R-type)
        vecs[11] = '{32'h00000000, 64'h0000_0000_0000_0000, 3'd0, 1'b1}; // all zeros
        vecs[12] = '{32'hFE208EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0}; // beq x1,x2,-4

        i_rst = 1'b0;
        i_Instruction = 32'h0;
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        i_Flush = 1'b0;

        // Asynchronous reset before any clock edge
        #1 i_rst = 1'b1;
        #2;
        check("reset o_Valid", {63'b0, o32_Valid}, 64'd0);
        check("reset o_Ready", {63'b0, o32_Ready}, 64'd1);
        check("reset imm", {32'b0, o32_Imm}, 64'd0);
        check("reset type", {61'b0, o32_ImmType}, 64'd0);
        check("reset illegal", {63'b0, o32_Illegal}, 64'd0);
        check("reset instr", {32'b0, o32_Instruction}, 64'd0);
        check("reset imm64", o64_Imm, 64'd0);
        @(negedge clk);
        i_rst = 1'b0;

        // Back-to-back decode table with i_Ready high: each beat appears one cycle later
        for (int i = 0; i < 13; i++) begin
            i_Instruction = vecs[i].ins;
            i_Valid = 1'b1;
            tick();
            check($sformatf("vec%0d valid", i), {63'b0, o32_Valid}, 64'd1);
            check($sformatf("vec%0d imm32", i), {32'b0, o32_Imm}, {32'b0, vecs[i].imm[31:0]});
            check($sformatf("vec%0d imm64", i), o64_Imm, vecs[i].imm);
            check($sformatf("vec%0d type", i), {61'b0, o32_ImmType}, {61'b0, vecs[i].typ});
            check($sformatf("vec%0d illegal", i), {63'b0, o32_Illegal}, {63'b0, vecs[i].ill});
            check($sformatf("vec%0d instr", i), {32'b0, o32_Instruction}, {32'b0, vecs[i].ins});
            check($sformatf("vec%0d type64", i), {61'b0, o64_ImmType}, {61'b0, vecs[i].typ});
            check($sformatf("vec%0d ready", i), {63'b0, o32_Ready}, 64'd1);
        end
        i_Valid = 1'b0;
        tick();
        check("drain valid", {63'b0, o32_Valid}, 64'd0);

        // Stall: A into M, B into S, C held upstream, then release in order
        i_Ready = 1'b0;
        i_Instruction = 32'h123450B7; i_Valid = 1'b1;
        tick();
        check("stall A valid", {63'b0, o32_Valid}, 64'd1);
        check("stall A instr", {32'b0, o32_Instruction}, 64'h123450B7);
        check("stall ready after A", {63'b0, o32_Ready}, 64'd1);
        i_Instruction = 32'hFE000EE3;
        tick();
        check("stall ready after B", {63'b0, o32_Ready}, 64'd0);
        check("stall M still A", {32'b0, o32_Instruction}, 64'h123450B7);
        i_Instruction = 32'h0010006F;
        tick();
        check("stall C held ready", {63'b0, o32_Ready}, 64'd0);
        check("stall C held M", {32'b0, o32_Instruction}, 64'h123450B7);
        i_Ready = 1'b1;
        check("out0 A valid", {63'b0, o32_Valid}, 64'd1);
        check("out0 A imm", {32'b0, o32_Imm}, 64'h12345000);
        tick();
        check("out1 B valid", {63'b0, o32_Valid}, 64'd1);
        check("out1 B instr", {32'b0, o32_Instruction}, 64'hFE000EE3);
        check("out1 B imm", {32'b0, o32_Imm}, 64'hFFFFFFFC);
        check("out1 ready", {63'b0, o32_Ready}, 64'd1);
        tick();
        check("out2 C valid", {63'b0, o32_Valid}, 64'd1);
        check("out2 C instr", {32'b0, o32_Instruction}, 64'h0010006F);
        check("out2 C imm", {32'b0, o32_Imm}, 64'h00000800);
        i_Valid = 1'b0;
        tick();
        check("out3 empty", {63'b0, o32_Valid}, 64'd0);

        // Flush with both registers full and a beat offered
        i_Ready = 1'b0;
        i_Valid = 1'b1;
        i_Instruction = 32'hFFF00093;
        tick();
        i_Instruction = 32'h7FF02283;
        tick();
        check("pre-flush ready", {63'b0, o32_Ready}, 64'd0);
        check("pre-flush valid", {63'b0, o32_Valid}, 64'd1);
        i_Flush = 1'b1;
        i_Instruction = 32'h00001017;
        tick();
        check("flush valid", {63'b0, o32_Valid}, 64'd0);
        check("flush ready", {63'b0, o32_Ready}, 64'd1);
        i_Flush = 1'b0;
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        tick();
        check("post-flush no beat 1", {63'b0, o32_Valid}, 64'd0);
        tick();
        check("post-flush no beat 2", {63'b0, o32_Valid}, 64'd0);

        // Illegal opcode, then asynchronous reset mid-stall
        i_Ready = 1'b0;
        i_Valid = 1'b1;
        i_Instruction = 32'h00000000;
        tick();
        check("zero-op valid", {63'b0, o32_Valid}, 64'd1);
        check("zero-op imm", {32'b0, o32_Imm}, 64'd0);
        check("zero-op type", {61'b0, o32_ImmType}, 64'd0);
        check("zero-op illegal", {63'b0, o32_Illegal}, 64'd1);
        i_Instruction = 32'hFFF00093;
        tick();
        check("pre-reset ready", {63'b0, o32_Ready}, 64'd0);
        i_Valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("midstall reset valid", {63'b0, o32_Valid}, 64'd0);
        check("midstall reset ready", {63'b0, o32_Ready}, 64'd1);
        check("midstall reset illegal", {63'b0, o32_Illegal}, 64'd0);
        check("midstall reset instr", {32'b0, o32_Instruction}, 64'd0);
        check("midstall reset imm", {32'b0, o32_Imm}, 64'd0);
        check("midstall reset ready64", {63'b0, o64_Ready}, 64'd1);
        @(negedge clk);
        i_rst = 1'b0;

        // Skid contents must be gone after reset: one fresh beat, then empty
        i_Ready = 1'b1;
        i_Valid = 1'b1;
        i_Instruction = 32'hFE20AC23;
        tick();
        check("post-reset beat instr", {32'b0, o32_Instruction}, 64'hFE20AC23);
        check("post-reset beat imm", {32'b0, o32_Imm}, 64'hFFFFFFF8);
        i_Valid = 1'b0;
        tick();
        check("post-reset empty", {63'b0, o32_Valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
